// File: rtl/axil_to_irq_adaptor.sv
// rtl/axil_to_irq_adaptor.sv - AXI4-Lite subordinate driving registered interrupt levels
//
// Purpose: terminates IRQ-notification writes and drives one registered level
// per target. Reads return the current levels.
// Registers (offset from base_addr_p, addr[1:0] ignored):
//   0x0 LEVEL (RW, strobed bytes replace)
//   0x4 SET   (WO, write-1-to-set, reads 0)
//   0x8 CLR   (WO, write-1-to-clear, reads 0)
//   0xC ID    (RO, num_targets_p)
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*          AXI-Lite write address / data / response
//   s_axil_ar*/r*             AXI-Lite read address / data
//   irq_o[num_targets_p]      interrupt levels, straight from flops
module axil_to_irq_adaptor #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter logic [axil_addr_width_p-1:0] base_addr_p = '0,
  parameter int num_targets_p = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [axil_addr_width_p-1:0] s_axil_awaddr_i,
  input  logic [2:0]                   s_axil_awprot_i,
  input  logic                         s_axil_awvalid_i,
  output logic                         s_axil_awready_o,
  input  logic [31:0]                  s_axil_wdata_i,
  input  logic [3:0]                   s_axil_wstrb_i,
  input  logic                         s_axil_wvalid_i,
  output logic                         s_axil_wready_o,
  output logic [1:0]                   s_axil_bresp_o,
  output logic                         s_axil_bvalid_o,
  input  logic                         s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
  input  logic [2:0]                   s_axil_arprot_i,
  input  logic                         s_axil_arvalid_i,
  output logic                         s_axil_arready_o,
  output logic [31:0]                  s_axil_rdata_o,
  output logic [1:0]                   s_axil_rresp_o,
  output logic                         s_axil_rvalid_o,
  input  logic                         s_axil_rready_i,
  output logic [num_targets_p-1:0]     irq_o
);

  localparam logic [1:0] resp_okay   = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;

  // live_q keeps every ready low while reset is held.
  logic                         live_q, live_d;
  logic                         aw_full_q, aw_full_d;
  logic [axil_addr_width_p-1:0] aw_addr_q, aw_addr_d;
  logic                         w_full_q, w_full_d;
  logic [31:0]                  w_data_q, w_data_d;
  logic [3:0]                   w_strb_q, w_strb_d;
  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic                         rvalid_q, rvalid_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic [num_targets_p-1:0]     irq_q, irq_d;

  logic                         aw_fire, w_fire, ar_fire, commit;
  logic [axil_addr_width_p-1:0] wr_addr, wr_off, rd_off;
  logic [31:0]                  wr_data, wr_bits, level_ext;
  logic [3:0]                   wr_strb;
  logic                         wr_hit, rd_hit;
  logic                         unused_bits;

  assign s_axil_awready_o = live_q && !aw_full_q;
  assign s_axil_wready_o  = live_q && !w_full_q;
  assign s_axil_arready_o = live_q && (!rvalid_q || s_axil_rready_i);
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_rdata_o   = rdata_q;
  assign irq_o            = irq_q;

  assign unused_bits = ^{s_axil_awprot_i, s_axil_arprot_i, wr_off[1:0], rd_off[1:0], wr_bits};

  always_comb begin
    live_d    = 1'b1;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    irq_d     = irq_q;

    aw_fire = s_axil_awvalid_i && s_axil_awready_o;
    w_fire  = s_axil_wvalid_i && s_axil_wready_o;
    ar_fire = s_axil_arvalid_i && s_axil_arready_o;

    // A beat arriving this cycle can commit straight away, giving the
    // one-cycle accept-to-irq latency without waiting for the holding reg.
    wr_addr = aw_full_q ? aw_addr_q : s_axil_awaddr_i;
    wr_data = w_full_q ? w_data_q : s_axil_wdata_i;
    wr_strb = w_full_q ? w_strb_q : s_axil_wstrb_i;
    commit  = (aw_full_q || aw_fire) && (w_full_q || w_fire) &&
              (!bvalid_q || s_axil_bready_i);

    wr_off = wr_addr - base_addr_p;
    wr_hit = (wr_off[axil_addr_width_p-1:4] == '0);
    for (int i = 0; i < 32; i++) begin
      wr_bits[i] = wr_data[i] && wr_strb[i/8];
    end

    level_ext = '0;
    level_ext[num_targets_p-1:0] = irq_q;
    rd_off = s_axil_araddr_i - base_addr_p;
    rd_hit = (rd_off[axil_addr_width_p-1:4] == '0);

    if (aw_fire) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axil_awaddr_i;
    end
    if (w_fire) begin
      w_full_d = 1'b1;
      w_data_d = s_axil_wdata_i;
      w_strb_d = s_axil_wstrb_i;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_hit ? resp_okay : resp_slverr;
      if (wr_hit) begin
        case (wr_off[3:2])
          2'd0:    irq_d = (irq_q & ~wr_mask_n()) | wr_bits[num_targets_p-1:0];
          2'd1:    irq_d = irq_q | wr_bits[num_targets_p-1:0];
          2'd2:    irq_d = irq_q & ~wr_bits[num_targets_p-1:0];
          default: irq_d = irq_q;
        endcase
      end
    end else if (s_axil_bready_i) begin
      bvalid_d = 1'b0;
    end

    // Read sees irq_q, so a read beside a commit returns the pre-write level.
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_hit ? resp_okay : resp_slverr;
      rdata_d  = '0;
      if (rd_hit) begin
        case (rd_off[3:2])
          2'd0:    rdata_d = level_ext;
          2'd3:    rdata_d = 32'(num_targets_p);
          default: rdata_d = '0;
        endcase
      end
    end else if (s_axil_rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  // Byte-lane mask of the strobed bits, limited to implemented targets.
  function automatic logic [num_targets_p-1:0] wr_mask_n();
    logic [num_targets_p-1:0] m;
    for (int i = 0; i < num_targets_p; i++) begin
      m[i] = wr_strb[i/8];
    end
    return m;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live_q    <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      irq_q     <= '0;
    end else begin
      live_q    <= live_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_axil_to_irq_adaptor.sv
// tb/tb_axil_to_irq_adaptor.sv - self-checking bench for axil_to_irq_adaptor
module tb_axil_to_irq_adaptor;

  localparam int NT = 4;
  localparam logic [31:0] BASE = 32'h4000_1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [NT-1:0] irq;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axil_to_irq_adaptor #(
    .axil_data_width_p(32), .axil_addr_width_p(32),
    .base_addr_p(BASE), .num_targets_p(NT)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(3'b000), .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
    .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arprot_i(3'b000), .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready),
    .irq_o(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Present AW and W together and drop each once its handshake is seen.
  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit af, wf;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 40 && (awvalid || wvalid); i++) begin
      af = awvalid && awready;
      wf = wvalid && wready;
      @(negedge clk);
      if (af) awvalid = 1'b0;
      if (wf) wvalid = 1'b0;
    end
    if (awvalid || wvalid) begin
      timeout("aw_w_accept");
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  // Wait for B; if bready is high the handshake edge is passed before returning.
  task automatic wait_b(output logic [1:0] resp);
    for (int i = 0; i < 40 && !bvalid; i++) @(negedge clk);
    resp = bresp;
    if (!bvalid) timeout("bvalid");
    else if (bready) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    send_aw_w(a, d, s);
    wait_b(resp);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit f;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    f = 1'b0;
    for (int i = 0; i < 40 && !f; i++) begin
      f = arready;
      @(negedge clk);
    end
    arvalid = 1'b0;
    if (!f || !rvalid) timeout("read");
    d = rdata; resp = rresp;
    if (rready) @(negedge clk);
  endtask

  // Reference model: rules applied per bit, independent of decode hardware.
  function automatic logic [NT-1:0] model_wr(logic [NT-1:0] cur, logic [31:0] off,
                                             logic [31:0] d, logic [3:0] s);
    logic [NT-1:0] r;
    r = cur;
    for (int i = 0; i < NT; i++) begin
      if (s[i/8]) begin
        if (off == 0) r[i] = d[i];
        else if (off == 4 && d[i]) r[i] = 1'b1;
        else if (off == 8 && d[i]) r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] off;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  exp_irq;
    logic [1:0]  exp_resp;
  } wvec_t;

  wvec_t tbl[12];

  initial begin
    logic [1:0]  r2;
    logic [31:0] d32, off, addr;
    logic [NT-1:0] lvl;
    bit f;

    tbl[0]  = '{32'h0, 32'h5,         4'hF, 4'h5, 2'b00};
    tbl[1]  = '{32'h4, 32'h2,         4'hF, 4'h7, 2'b00};
    tbl[2]  = '{32'h8, 32'h4,         4'hF, 4'h3, 2'b00};
    tbl[3]  = '{32'h0, 32'h0,         4'hF, 4'h0, 2'b00};
    tbl[4]  = '{32'h0, 32'hFFFF_FFFF, 4'h0, 4'h0, 2'b00};
    tbl[5]  = '{32'h0, 32'hFFFF_FFFF, 4'h1, 4'hF, 2'b00};
    tbl[6]  = '{32'h0, 32'h0,         4'hE, 4'hF, 2'b00};
    tbl[7]  = '{32'h10, 32'h0,        4'hF, 4'hF, 2'b10};
    tbl[8]  = '{32'hC, 32'h0,         4'hF, 4'hF, 2'b00};
    tbl[9]  = '{32'h8, 32'hFFFF_FF0A, 4'h2, 4'hF, 2'b00};
    tbl[10] = '{32'h8, 32'hA,         4'h1, 4'h5, 2'b00};
    tbl[11] = '{32'h4, 32'hF0,        4'hF, 4'h5, 2'b00};

    // Reset state, readies low while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);

    // Reset mid-write: an AW to a bad address is held, then reset drops it.
    awaddr = BASE + 32'h10; awvalid = 1'b1;
    f = 1'b0;
    for (int i = 0; i < 20 && !f; i++) begin
      f = awready;
      @(negedge clk);
    end
    awvalid = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk("midrst_awready", 32'(awready), 0);
    chk("midrst_irq", 32'(irq), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_bvalid", 32'(bvalid), 0);
    do_write(BASE, 32'h1, 4'hF, r2);
    chk("midrst_bresp", 32'(r2), 0);
    chk("midrst_irq1", 32'(irq), 1);

    // Ordering: W three cycles ahead of AW.
    do_write(BASE, 32'h0, 4'hF, r2);
    @(negedge clk);
    wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    f = 1'b0;
    for (int i = 0; i < 20 && !f; i++) begin
      f = wready;
      @(negedge clk);
    end
    wvalid = 1'b0;
    repeat (3) begin
      chk("order_wready_low", 32'(wready), 0);
      chk("order_no_b", 32'(bvalid), 0);
      chk("order_irq0", 32'(irq), 0);
      @(negedge clk);
    end
    awaddr = BASE; awvalid = 1'b1;
    f = 1'b0;
    for (int i = 0; i < 20 && !f; i++) begin
      f = awready;
      @(negedge clk);
    end
    awvalid = 1'b0;
    chk("order_irq1", 32'(irq), 1);
    chk("order_bvalid", 32'(bvalid), 1);
    @(negedge clk);
    chk("order_single_b", 32'(bvalid), 0);

    // Table-driven register writes.
    for (int k = 0; k < 12; k++) begin
      do_write(BASE + tbl[k].off, tbl[k].data, tbl[k].strb, r2);
      chk($sformatf("tbl%0d_bresp", k), 32'(r2), 32'(tbl[k].exp_resp));
      chk($sformatf("tbl%0d_irq", k), 32'(irq), 32'(tbl[k].exp_irq));
    end
    do_read(BASE, d32, r2);
    chk("rd_level", d32, 5);
    chk("rd_level_resp", 32'(r2), 0);
    do_read(BASE + 32'hC, d32, r2);
    chk("rd_id", d32, NT);
    do_read(BASE + 32'h8, d32, r2);
    chk("rd_clr", d32, 0);
    do_read(BASE + 32'h10, d32, r2);
    chk("rd_bad_data", d32, 0);
    chk("rd_bad_resp", 32'(r2), 2);

    // Read beside a write commit returns the old level.
    @(negedge clk);
    awaddr = BASE; wdata = 32'hA; wstrb = 4'hF; araddr = BASE;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_cyc_rdata", rdata, 5);
    chk("same_cyc_irq", 32'(irq), 32'hA);
    @(negedge clk);

    // B backpressure: second write held until bready.
    bready = 1'b0;
    do_write(BASE, 32'h3, 4'hF, r2);
    send_aw_w(BASE, 32'hC, 4'hF);
    repeat (3) begin
      chk("bp_irq_hold", 32'(irq), 3);
      chk("bp_bvalid_hold", 32'(bvalid), 1);
      chk("bp_awready", 32'(awready), 0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("bp_irq_new", 32'(irq), 32'hC);
    chk("bp_bvalid2", 32'(bvalid), 1);
    @(negedge clk);
    chk("bp_bvalid_done", 32'(bvalid), 0);

    // R backpressure.
    rready = 1'b0;
    do_read(BASE, d32, r2);
    chk("rbp_rdata", d32, 32'hC);
    araddr = BASE + 32'hC; arvalid = 1'b1;
    repeat (3) begin
      chk("rbp_arready", 32'(arready), 0);
      chk("rbp_rdata_stable", rdata, 32'hC);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rbp_next_rdata", rdata, NT);
    chk("rbp_next_rvalid", 32'(rvalid), 1);
    @(negedge clk);
    chk("rbp_rvalid_done", 32'(rvalid), 0);

    // Randomized traffic against the reference model.
    lvl = irq == 4'hC ? 4'hC : 4'hC;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 6))
        0: off = 32'h0;  1: off = 32'h4;  2: off = 32'h8;  3: off = 32'hC;
        4: off = 32'h10; 5: off = 32'h100; default: off = 32'hFFFF_FFFC;
      endcase
      addr = BASE + off + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        d32 = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        do_write(addr, d32, wstrb, r2);
        lvl = (off <= 32'hC) ? model_wr(lvl, off, d32, wstrb) : lvl;
        chk("rnd_bresp", 32'(r2), (off <= 32'hC) ? 0 : 2);
        chk("rnd_irq", 32'(irq), 32'(lvl));
      end else begin
        do_read(addr, d32, r2);
        chk("rnd_rresp", 32'(r2), (off <= 32'hC) ? 0 : 2);
        chk("rnd_rdata", d32, (off == 0) ? 32'(lvl) : (off == 32'hC) ? NT : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
